mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencing controller for the 16-bit repeated-addition multiplier datapath (A register, P accumulator with clear, B down-counter, adder, zero-detect).
- Accepts two operand beats (A then B) on the shared data bus through a valid/ready handshake.
- Drives the datapath load, clear and decrement strobes, and watches eqz to end accumulation.
- Reports done/busy/error and the iteration count. Replaces the free-running start-triggered controller; B=0 is handled correctly and there are no intra-procedural delays.

Parameters:
- WIDTH, 16, operand/bus width; must match the datapath.
- MAX_ITER, 65535, accumulate cycles allowed before err is flagged; legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock, shared with the datapath.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an operand beat on data_in (data_in goes straight to the datapath bus).
- in_ready  output  1  controller accepts the beat this cycle.
- abort  input  1  synchronous cancel of the current operation.
- eqz  input  1  datapath B counter == 0, combinational from the B register.
- ldA  output  1  load A register.
- ldB  output  1  load B counter.
- ldP  output  1  load P accumulator with adder output.
- clrP  output  1  clear P accumulator.
- decB  output  1  decrement B counter.
- busy  output  1  operation in progress (any state except IDLE).
- done  output  1  one-cycle pulse: P holds the result.
- err  output  1  one-cycle pulse: MAX_ITER exceeded, P invalid.
- iter_cnt  output  WIDTH  accumulate cycles executed for the current or last operation.

Behaviour:
- States: IDLE, GET_A, GET_B, ACCUM, DONE, ERR. Encoding is held in the shared package.
- Reset (rst_n=0, any time, including mid-operation):
  - State goes to IDLE and iter_cnt goes to 0.
  - All outputs 0 immediately.
  - Datapath register contents are don't-care after reset.
- IDLE: in_ready=0, all strobes 0. Next state is GET_A unconditionally.
- GET_A:
  - in_ready=1; ldA = in_valid.
  - On in_valid, A captures data_in at the edge, iter_cnt clears to 0, and the state moves to GET_B.
  - Otherwise the state holds; gaps of any length are allowed.
- GET_B:
  - in_ready=1; ldB = in_valid; clrP = in_valid.
  - On in_valid, B loads, P clears and the state moves to ACCUM.
- ACCUM (eqz is valid from the first ACCUM cycle because B loaded at the previous edge):
  - eqz=1: ldP=0, decB=0, next state DONE. B=0 therefore gives P=0 with zero adds.
  - eqz=0 and iter_cnt == MAX_ITER: no strobes, next state ERR.
  - Otherwise: ldP=1, decB=1 in the same cycle (P <= P+A, B <= B-1), iter_cnt+1, stay in ACCUM.
- DONE: done=1 for exactly one cycle with no strobes; next state GET_A. P is stable until the next accepted B beat.
- ERR: err=1 for one cycle; next state GET_A.
- abort:
  - In GET_B or ACCUM, abort goes to GET_A next edge with no strobes that cycle; done/err are not pulsed.
  - abort has priority over in_valid and eqz.
  - abort is ignored in IDLE, GET_A, DONE and ERR.
- Strobe rules:
  - ldA, ldB, clrP and ldP/decB are mutually exclusive by state.
  - clrP and ldP are never high together.
  - Outputs are functions of the current state plus in_valid/eqz/abort only; there is no registered-output latency.
- Arithmetic:
  - Result is A*B mod 2^WIDTH; P wraps silently (adder carry discarded).
  - iter_cnt is WIDTH bits and saturates at MAX_ITER, never wraps.
- Latency: from the edge accepting B to the done pulse is B+1 cycles (B accumulate cycles plus one eqz-detect cycle), with done asserted in the following cycle.
- Back-to-back operation: the GET_A after DONE accepts a new A immediately.

Decomposition:
- Package mul_ctrl_pkg:
  - state_t enum (IDLE, GET_A, GET_B, ACCUM, DONE, ERR), 3-bit.
  - Localparam WIDTH_DEF=16.
  - Localparam MAX_ITER_DEF.
- No sub-module inside the controller.
- A top wrapper mul_seq_top pairs mul_seq_ctrl with the datapath for benching; the wrapper is not part of this block.

Test Plan:
- A=5, B=3 back-to-back beats:
  - Strobes run ldA, then ldB+clrP, then three cycles of ldP+decB, then one eqz cycle.
  - Result: done pulse, P=15, iter_cnt=3.
- A=7, B=0 -> no ldP ever; done on the second ACCUM-following cycle; P=0, iter_cnt=0.
- A=0xFFFF, B=2 with 3 idle cycles between beats -> in_ready held high through the gap; P=0xFFFE (wrap); iter_cnt=2.
- MAX_ITER=4, A=1, B=10 -> four ldP cycles, then err pulse with no done; iter_cnt=4; next state GET_A.
- A=3, B=8; abort after 2 accumulate cycles -> no strobes that cycle; no done/err; GET_A next; a new 2x2 operation then yields P=4.
- rst_n low during ACCUM of A=9, B=5 -> all outputs 0 immediately; after release the state goes IDLE then GET_A; a 4x4 operation completes with P=16.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// mul_ctrl_pkg: shared state encoding and default sizing for the multiplier controller
package mul_ctrl_pkg;
    localparam int WIDTH_DEF    = 16;
    localparam int MAX_ITER_DEF = 65535;
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, ACCUM, DONE, ERR} state_t;
endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: operand-beat handshake and cancel between upstream and the controller
interface mul_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic abort;
    modport master (output in_valid, output abort, input in_ready);
    modport slave  (input in_valid, input abort, output in_ready);
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequences A/B operand capture and repeated-addition accumulate
// for the multiplier datapath, with iteration limit and abort.
module mul_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_seq_ctrl_if.slave    bus,
    input  logic             eqz,
    output logic             ldA,
    output logic             ldB,
    output logic             ldP,
    output logic             clrP,
    output logic             decB,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] iter_cnt
);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_ITER);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_iter;
    logic             w_at_limit;
    assign w_at_limit = r_iter == LIMIT;
    assign iter_cnt   = r_iter;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // ldP only fires below the limit, so the counter saturates without its own guard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_iter <= '0;
        else if (ldA) r_iter <= '0;
        else if (ldP) r_iter <= r_iter + 1'b1;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = GET_A;
            GET_A:   w_next = bus.in_valid ? GET_B : GET_A;
            GET_B:   w_next = bus.abort ? GET_A : bus.in_valid ? ACCUM : GET_B;
            ACCUM:   w_next = bus.abort ? GET_A : eqz ? DONE : w_at_limit ? ERR : ACCUM;
            DONE:    w_next = GET_A;
            ERR:     w_next = GET_A;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        bus.in_ready = r_state == GET_A || r_state == GET_B;
        ldA          = r_state == GET_A && bus.in_valid;
        ldB          = r_state == GET_B && bus.in_valid && !bus.abort;
        clrP         = ldB;
        ldP          = r_state == ACCUM && !bus.abort && !eqz && !w_at_limit;
        decB         = ldP;
        busy         = r_state != IDLE;
        done         = r_state == DONE;
        err          = r_state == ERR;
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed scenarios for mul_seq_ctrl driving a behavioural datapath;
// u0 uses the default limit, u1 uses MAX_ITER=4.
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    int          checks = 0;
    int          errors = 0;
    mul_seq_ctrl_if if0();
    mul_seq_ctrl_if if1();
    logic ldA0, ldB0, ldP0, clrP0, decB0, busy0, done0, err0;
    logic ldA1, ldB1, ldP1, clrP1, decB1, busy1, done1, err1;
    logic [15:0] iter0, iter1, a0, b0, p0, a1, b1, p1;
    logic        eqz0, eqz1;
    logic [8:0]  outs0, outs1;
    logic [4:0]  s0;
    assign eqz0  = b0 == 16'd0;
    assign eqz1  = b1 == 16'd0;
    assign s0    = {ldA0, ldB0, clrP0, ldP0, decB0};
    assign outs0 = {if0.in_ready, s0, busy0, done0, err0};
    assign outs1 = {if1.in_ready, ldA1, ldB1, clrP1, ldP1, decB1, busy1, done1, err1};

    always #5 clk = ~clk;

    mul_seq_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .eqz(eqz0),
        .ldA(ldA0), .ldB(ldB0), .ldP(ldP0), .clrP(clrP0), .decB(decB0),
        .busy(busy0), .done(done0), .err(err0), .iter_cnt(iter0)
    );
    mul_seq_ctrl #(.MAX_ITER(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .eqz(eqz1),
        .ldA(ldA1), .ldB(ldB1), .ldP(ldP1), .clrP(clrP1), .decB(decB1),
        .busy(busy1), .done(done1), .err(err1), .iter_cnt(iter1)
    );

    // Behavioural datapath: A register, B down-counter, P accumulator with wrap
    always_ff @(posedge clk) begin
        if (ldA0) a0 <= data;
        if (ldB0) b0 <= data;
        else if (decB0) b0 <= b0 - 16'd1;
        if (clrP0) p0 <= '0;
        else if (ldP0) p0 <= p0 + a0;
    end
    always_ff @(posedge clk) begin
        if (ldA1) a1 <= data;
        if (ldB1) b1 <= data;
        else if (decB1) b1 <= b1 - 16'd1;
        if (clrP1) p1 <= '0;
        else if (ldP1) p1 <= p1 + a1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [15:0] a, input logic [15:0] b);
        if0.in_valid = 1'b1;
        data = a;
        step();
        data = b;
        step();
        if0.in_valid = 1'b0;
    endtask

    task automatic run0(output int cyc, output int nldp, output logic [15:0] p, output logic [15:0] it);
        int n = 0;
        cyc = 0;
        nldp = 0;
        p = 'x;
        it = 'x;
        while (cyc == 0 && n < 64) begin
            @(negedge clk);
            n++;
            if (ldP0) nldp++;
            if (done0) begin
                cyc = n;
                p = p0;
                it = iter0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (outs0 !== 9'd0) begin errors++; $display("FAIL reset_outs0 got %b exp 0", outs0); end
        checks++; if (iter0 !== 16'd0) begin errors++; $display("FAIL reset_iter0 got %0d exp 0", iter0); end
        checks++; if (outs1 !== 9'd0) begin errors++; $display("FAIL reset_outs1 got %b exp 0", outs1); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (outs0 !== 9'd0) begin errors++; $display("FAIL idle_outs got %b exp 0", outs0); end
        step();
        @(negedge clk);
        checks++; if (outs0 !== 9'b1_00000_100) begin errors++; $display("FAIL geta_outs got %b exp 100000100", outs0); end
        step();
    endtask

    task automatic test_basic();
        if0.in_valid = 1'b1;
        data = 16'd5;
        @(negedge clk);
        checks++; if (s0 !== 5'b10000 || !if0.in_ready) begin errors++; $display("FAIL basic_lda got %b exp 10000", s0); end
        step();
        data = 16'd3;
        @(negedge clk);
        checks++; if (s0 !== 5'b01100 || !if0.in_ready) begin errors++; $display("FAIL basic_ldb got %b exp 01100", s0); end
        step();
        if0.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (s0 !== 5'b00011 || iter0 !== 16'(i)) begin errors++; $display("FAIL basic_acc%0d got %b/%0d exp 00011/%0d", i, s0, iter0, i); end
            step();
        end
        @(negedge clk);
        checks++; if (s0 !== 5'd0 || done0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL basic_eqz got %b done %b", s0, done0); end
        step();
        @(negedge clk);
        checks++; if (done0 !== 1'b1 || s0 !== 5'd0) begin errors++; $display("FAIL basic_done got %b exp 1", done0); end
        checks++; if (p0 !== 16'd15 || iter0 !== 16'd3) begin errors++; $display("FAIL basic_result got %0d/%0d exp 15/3", p0, iter0); end
        step();
    endtask

    task automatic test_back_to_back_zero_b();
        if0.in_valid = 1'b1;
        data = 16'd7;
        @(negedge clk);
        checks++; if (ldA0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL b2b_lda got %b exp 1", ldA0); end
        step();
        data = 16'd0;
        step();
        if0.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (s0 !== 5'd0 || done0 !== 1'b0) begin errors++; $display("FAIL zb_accum got %b exp 00000", s0); end
        step();
        @(negedge clk);
        checks++; if (done0 !== 1'b1 || p0 !== 16'd0 || iter0 !== 16'd0) begin errors++; $display("FAIL zb_done got %b p %0d it %0d exp 1/0/0", done0, p0, iter0); end
        step();
    endtask

    task automatic test_gap_wrap();
        int cyc, nldp;
        logic [15:0] p, it;
        if0.in_valid = 1'b1;
        data = 16'hFFFF;
        step();
        if0.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (if0.in_ready !== 1'b1 || s0 !== 5'd0 || busy0 !== 1'b1) begin errors++; $display("FAIL gap%0d rdy %b strobes %b exp 1/00000", i, if0.in_ready, s0); end
            step();
        end
        if0.in_valid = 1'b1;
        data = 16'd2;
        @(negedge clk);
        checks++; if (s0 !== 5'b01100) begin errors++; $display("FAIL gap_ldb got %b exp 01100", s0); end
        step();
        if0.in_valid = 1'b0;
        run0(cyc, nldp, p, it);
        checks++; if (cyc !== 4 || nldp !== 2) begin errors++; $display("FAIL wrap_timing cyc %0d ldp %0d exp 4/2", cyc, nldp); end
        checks++; if (p !== 16'hFFFE || it !== 16'd2) begin errors++; $display("FAIL wrap_result got %h/%0d exp fffe/2", p, it); end
    endtask

    task automatic test_max_iter();
        int n = 0, ecyc = 0, nldp = 0;
        bit saw_done = 0;
        logic [15:0] it = '0;
        if1.in_valid = 1'b1;
        data = 16'd1;
        step();
        data = 16'd10;
        step();
        if1.in_valid = 1'b0;
        while (ecyc == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (ldP1) nldp++;
            if (done1) saw_done = 1;
            if (err1) begin
                ecyc = n;
                it = iter1;
            end
            step();
        end
        checks++; if (ecyc !== 6 || nldp !== 4 || saw_done) begin errors++; $display("FAIL maxit_timing cyc %0d ldp %0d done %0d exp 6/4/0", ecyc, nldp, saw_done); end
        checks++; if (it !== 16'd4 || p1 !== 16'd4) begin errors++; $display("FAIL maxit_count got %0d p %0d exp 4/4", it, p1); end
        @(negedge clk);
        checks++; if (outs1 !== 9'b1_00000_100) begin errors++; $display("FAIL maxit_geta got %b exp 100000100", outs1); end
        step();
    endtask

    task automatic test_abort();
        int cyc, nldp;
        logic [15:0] p, it;
        load0(16'd3, 16'd8);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (s0 !== 5'b00011) begin errors++; $display("FAIL abort_acc%0d got %b exp 00011", i, s0); end
            step();
        end
        if0.abort = 1'b1;
        @(negedge clk);
        checks++; if (s0 !== 5'd0 || done0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL abort_cycle got %b d%b e%b exp 00000", s0, done0, err0); end
        step();
        if0.abort = 1'b0;
        @(negedge clk);
        checks++; if (outs0 !== 9'b1_00000_100 || p0 !== 16'd6 || iter0 !== 16'd2) begin errors++; $display("FAIL abort_geta got %b p %0d it %0d exp 100000100/6/2", outs0, p0, iter0); end
        step();
        load0(16'd2, 16'd2);
        run0(cyc, nldp, p, it);
        checks++; if (cyc !== 4 || p !== 16'd4 || it !== 16'd2) begin errors++; $display("FAIL abort_next cyc %0d p %0d it %0d exp 4/4/2", cyc, p, it); end
    endtask

    task automatic test_reset_mid_op();
        int cyc, nldp;
        logic [15:0] p, it;
        load0(16'd9, 16'd5);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (outs0 !== 9'd0 || iter0 !== 16'd0) begin errors++; $display("FAIL rst_async got %b it %0d exp 0/0", outs0, iter0); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (outs0 !== 9'd0) begin errors++; $display("FAIL rst_idle got %b exp 0", outs0); end
        step();
        @(negedge clk);
        checks++; if (if0.in_ready !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL rst_geta rdy %b busy %b exp 1/1", if0.in_ready, busy0); end
        step();
        load0(16'd4, 16'd4);
        run0(cyc, nldp, p, it);
        checks++; if (cyc !== 6 || nldp !== 4 || p !== 16'd16 || it !== 16'd4) begin errors++; $display("FAIL rst_next cyc %0d ldp %0d p %0d it %0d exp 6/4/16/4", cyc, nldp, p, it); end
    endtask

    initial begin
        if0.in_valid = 1'b0;
        if0.abort = 1'b0;
        if1.in_valid = 1'b0;
        if1.abort = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back_zero_b();
        test_gap_wrap();
        test_max_iter();
        test_abort();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
